// File: rtl/half_adder.sv
// Purpose: registered, lane-parallel half adder (sum/carry per lane) with carry summary outputs.
// Latency: 1 cycle from accepted operand to out_valid; 1 result/cycle while out_ready=1.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds all outputs.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake; in1/in2 are WIDTH-bit operands, one bit per lane
//   out_valid/out_ready result handshake
//   out, car          per-lane sum (in1^in2) and carry (in1&in2)
//   carry_any         OR of car
//   carry_count       population count of car (0..WIDTH)
// Optional: define HA_STATS_EN to add xfer_count and carry_event_count (32-bit, wrapping).
module half_adder #(
  parameter  int WIDTH = 1,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] car,
  output logic             carry_any,
  output logic [CNT_W-1:0] carry_count
`ifdef HA_STATS_EN
  ,
  output logic [31:0]      xfer_count,
  output logic [31:0]      carry_event_count
`endif
);

  logic             xfer;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] car_d;
  logic [CNT_W-1:0] cnt_d;

  // Combinational ready lets a full register be replaced in the cycle it drains.
  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  assign sum_d = in1 ^ in2;
  assign car_d = in1 & in2;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d = cnt_d + CNT_W'(car_d[i]);
    end
  end

  // Data registers load only on a transfer, so operands presented without
  // in_valid (including unknown values) never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out         <= '0;
      car         <= '0;
      carry_any   <= 1'b0;
      carry_count <= '0;
    end else begin
      if (xfer) begin
        out_valid   <= 1'b1;
        out         <= sum_d;
        car         <= car_d;
        carry_any   <= |car_d;
        carry_count <= cnt_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef HA_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count        <= '0;
      carry_event_count <= '0;
    end else if (xfer) begin
      xfer_count <= xfer_count + 32'd1;
      if (|car_d) begin
        carry_event_count <= carry_event_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Bench for half_adder: an 8-lane and a 1-lane instance checked against a
// per-lane arithmetic model through scoreboard queues, plus directed checks
// for reset, backpressure and (with HA_STATS_EN) the transfer counters.
module tb_half_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, ov8, or8, ca8;
  logic [7:0] a8, b8, o8, c8;
  logic [3:0] cc8;

  logic       iv1, ir1, ov1, or1, ca1;
  logic [0:0] a1, b1, o1, c1, cc1;

`ifdef HA_STATS_EN
  logic [31:0] xc8, ce8, xc1, ce1;
  int unsigned exp_xfer, exp_cev;
`endif

  half_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .in1(a8), .in2(b8),
    .out_valid(ov8), .out_ready(or8), .out(o8), .car(c8),
    .carry_any(ca8), .carry_count(cc8)
`ifdef HA_STATS_EN
    , .xfer_count(xc8), .carry_event_count(ce8)
`endif
  );

  half_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1), .in1(a1), .in2(b1),
    .out_valid(ov1), .out_ready(or1), .out(o1), .car(c1),
    .carry_any(ca1), .carry_count(cc1)
`ifdef HA_STATS_EN
    , .xfer_count(xc1), .carry_event_count(ce1)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: each lane adds two bits arithmetically; low bit is sum, high bit carry.
  function automatic logic [20:0] model8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s, c;
    logic [1:0] t;
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      t = {1'b0, a[i]} + {1'b0, b[i]};
      s[i] = t[0];
      c[i] = t[1];
      n += int'(t[1]);
    end
    return {s, c, (n != 0), 4'(n)};
  endfunction

  function automatic logic [3:0] model1(input logic a, input logic b);
    logic [1:0] t;
    t = {1'b0, a} + {1'b0, b};
    return {t[0], t[1], t[1], t[1]};
  endfunction

  logic [20:0] q8[$];
  logic [3:0]  q1[$];

  // Scoreboard: compare on output transfer, push on input transfer.
  always @(negedge clk) begin
    logic [20:0] e8;
    logic [3:0]  e1;
    if (rst) begin
      q8.delete();
      q1.delete();
`ifdef HA_STATS_EN
      exp_xfer = 0;
      exp_cev  = 0;
`endif
    end else begin
      check("ov8", ov8, q8.size() != 0);
      check("ir8", ir8, (q8.size() == 0) || or8);
      if (ov8 && or8 && q8.size() != 0) begin
        e8 = q8.pop_front();
        check("sb8_out", o8,  e8[20:13]);
        check("sb8_car", c8,  e8[12:5]);
        check("sb8_any", ca8, e8[4]);
        check("sb8_cnt", cc8, e8[3:0]);
      end
      if (iv8 && ir8) begin
        q8.push_back(model8(a8, b8));
`ifdef HA_STATS_EN
        exp_xfer++;
        if ((a8 & b8) != 8'h00) exp_cev++;
`endif
      end

      check("ov1", ov1, q1.size() != 0);
      check("ir1", ir1, (q1.size() == 0) || or1);
      if (ov1 && or1 && q1.size() != 0) begin
        e1 = q1.pop_front();
        check("sb1_out", o1,  e1[3]);
        check("sb1_car", c1,  e1[2]);
        check("sb1_any", ca1, e1[1]);
        check("sb1_cnt", cc1, e1[0]);
      end
      if (iv1 && ir1) q1.push_back(model1(a1[0], b1[0]));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] va [3] = '{8'hF0, 8'hFF, 8'hAA};
  logic [7:0] vb [3] = '{8'h3C, 8'hFF, 8'h55};
  logic [7:0] sa [5] = '{8'h01, 8'h03, 8'h00, 8'h88, 8'h04};
  logic [7:0] sb [5] = '{8'h02, 8'h01, 8'h0F, 8'h08, 8'h03};

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
    iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0;
    step(2);
    check("rst_ov8", ov8, 0);
    check("rst_out8", o8, 0);
    check("rst_car8", c8, 0);
    check("rst_any8", ca8, 0);
    check("rst_cnt8", cc8, 0);
    check("rst_ov1", ov1, 0);
`ifdef HA_STATS_EN
    check("rst_xfer", xc8, 0);
    check("rst_cev", ce8, 0);
`endif
    rst = 1'b0;
    step(1);

    // Scalar truth table on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      iv1 = 1'b1;
      a1[0] = i[1];
      b1[0] = i[0];
      step(1);
    end
    iv1 = 1'b0;
    step(2);

    // 8-lane directed vectors, back to back.
    for (int i = 0; i < 3; i++) begin
      iv8 = 1'b1;
      a8 = va[i];
      b8 = vb[i];
      step(1);
    end
    iv8 = 1'b0;
    step(2);

    // Backpressure: hold a result for 3 cycles while new data waits.
    iv8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
    step(1);
    or8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ir", ir8, 0);
      check("stall_ov", ov8, 1);
      check("stall_out", o8, 8'hCC);
      check("stall_car", c8, 8'h30);
      check("stall_cnt", cc8, 2);
      step(1);
    end
    or8 = 1'b1;
    step(1);
    iv8 = 1'b0;
    check("release_ov", ov8, 1);
    check("release_out", o8, 8'h00);
    check("release_car", c8, 8'hFF);
    check("release_cnt", cc8, 8);
    step(2);

    // Random traffic with random backpressure on both instances.
    for (int i = 0; i < 200; i++) begin
      iv8 = 1'($urandom_range(0, 1));
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      or8 = ($urandom_range(0, 3) != 0);
      iv1 = 1'($urandom_range(0, 1));
      a1  = 1'($urandom);
      b1  = 1'($urandom);
      or1 = ($urandom_range(0, 2) != 0);
      step(1);
    end
    iv8 = 1'b0; or8 = 1'b1;
    iv1 = 1'b0; or1 = 1'b1;
    step(3);

    // Reset while a result is held and a new operand is offered.
    iv8 = 1'b1; a8 = 8'h5A; b8 = 8'hF3; or8 = 1'b0;
    step(1);
    a8 = 8'hFF; b8 = 8'hFF; or8 = 1'b1;
    rst = 1'b1;
    step(1);
    check("mid_rst_ov", ov8, 0);
    check("mid_rst_out", o8, 0);
    check("mid_rst_car", c8, 0);
    check("mid_rst_cnt", cc8, 0);
`ifdef HA_STATS_EN
    check("mid_rst_xfer", xc8, 0);
    check("mid_rst_cev", ce8, 0);
`endif
    rst = 1'b0;
    iv8 = 1'b0;
    step(2);

    // Five operands, two of which produce a carry.
    for (int i = 0; i < 5; i++) begin
      iv8 = 1'b1;
      a8 = sa[i];
      b8 = sb[i];
      step(1);
    end
    iv8 = 1'b0;
    step(1);
`ifdef HA_STATS_EN
    check("stats_xfer", xc8, 5);
    check("stats_cev", ce8, 2);
`endif

    for (int i = 0; i < 20 && (q8.size() + q1.size()) != 0; i++) step(1);
    check("sb_drain", 32'(q8.size() + q1.size()), 0);
`ifdef HA_STATS_EN
    check("stats_xfer_model", xc8, exp_xfer);
    check("stats_cev_model", ce8, exp_cev);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Registered, lane-parallel half adder: WIDTH independent 1-bit half adders, sum = in1 XOR in2, carry = in1 AND in2 per lane.
- Single output register stage behind a valid/ready handshake, with lane-summary outputs (carry_any, carry_count).
- Leaf arithmetic primitive; WIDTH=1 is the scalar half adder used by adder trees and counters elsewhere in the design.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (>=1).
- CNT_W, $clog2(WIDTH+1), width of carry_count; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in1/in2 carry a valid operand pair.
- in_ready  output  1  block accepts an operand this cycle.
- in1  input  WIDTH  operand A, one bit per lane.
- in2  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  out/car/carry_any/carry_count hold a valid result.
- out_ready  input  1  downstream consumes the result this cycle.
- out  output  WIDTH  per-lane sum, in1[i]^in2[i].
- car  output  WIDTH  per-lane carry, in1[i]&in2[i].
- carry_any  output  1  OR-reduction of car.
- carry_count  output  CNT_W  population count of car.

Behaviour:
- Reset: on a clk edge with rst=1, out_valid=0, out=0, car=0, carry_any=0, carry_count=0. Reset overrides any simultaneous transfer; an in-flight result is discarded.
- in_ready = !out_valid || out_ready. This is combinational, so a full register is replaced in the same cycle it drains.
- Accept: a transfer occurs when in_valid && in_ready. At the next edge:
  - out <= in1^in2, car <= in1&in2.
  - carry_any <= |(in1&in2), carry_count <= popcount(in1&in2).
  - out_valid <= 1.
- Drain: out_valid && out_ready && !(in_valid && in_ready) -> out_valid <= 0. Data registers hold their last value; content is don't-care while out_valid=0.
- Stall: out_valid && !out_ready -> all output registers hold; in_ready=0.
- Latency: exactly 1 cycle from accept to out_valid. Throughput is 1 result/cycle while out_ready=1.
- Arithmetic: no carry-in and no inter-lane ripple; each lane is independent. Per lane, the 2-bit value {car[i],out[i]} equals in1[i]+in2[i] (range 0..2).
- carry_count range is 0..WIDTH; its width always fits WIDTH.
- in1/in2 values are ignored whenever in_valid=0. X on unused inputs must not propagate to the outputs.

Optional Feature:
- Macro HA_STATS_EN.
- Defined: adds output ports xfer_count (32 bits) and carry_event_count (32 bits).
  - xfer_count increments on every accepted input.
  - carry_event_count increments on every accepted input with nonzero carry.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- WIDTH=1, out_ready=1, apply (in1,in2) = (0,0),(0,1),(1,0),(1,1) on consecutive cycles -> one cycle later (out,car) = (0,0),(1,0),(1,0),(0,1); carry_count = 0,0,0,1.
- WIDTH=8, in1=8'hF0, in2=8'h3C -> out=8'hCC, car=8'h30, carry_any=1, carry_count=2.
- WIDTH=8, in1=8'hFF, in2=8'hFF -> out=8'h00, car=8'hFF, carry_count=8. Then in1=8'hAA, in2=8'h55 -> out=8'hFF, car=8'h00, carry_any=0.
- Backpressure: accept a result, hold out_ready=0 for 3 cycles while in_valid=1 with new data -> in_ready=0, outputs unchanged. Release out_ready -> new result appears the next cycle with no gap or loss.
- Assert rst while out_valid=1 and in_valid=1 -> next edge: out_valid=0, out=0, car=0, carry_count=0. With HA_STATS_EN: counters read 0.
- HA_STATS_EN, WIDTH=4: accept 5 operands, 2 of them with nonzero carry -> xfer_count=5, carry_event_count=2.
